// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin arbiter for two requesters sharing one fixed-latency FP datapath, with per-requester credited FWFT result FIFOs
module fpu_arbiter #(
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_b1,
  input  logic [1:0]  req_op,
  output logic        dp_valid,
  output logic        dp_op,
  output logic [31:0] dp_a,
  output logic [31:0] dp_b,
  input  logic [31:0] dp_result,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_data0,
  output logic [31:0] rsp_data1,
  output logic        busy
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  logic [CW-1:0]  credit_q [2], credit_d [2];
  logic [CW-1:0]  cnt_q [2], cnt_d [2];
  logic [PW-1:0]  wptr_q [2], wptr_d [2], rptr_q [2], rptr_d [2];
  logic [31:0]    mem_q [2][DEPTH], mem_d [2][DEPTH];
  logic           prio_q, prio_d, issue_v_q, issue_v_d, issue_id_q, issue_id_d, op_q, op_d;
  logic [31:0]    a_q, a_d, b_q, b_d;
  logic [LAT-1:0] tag_v_q, tag_v_d, tag_id_q, tag_id_d;
  logic [1:0]     elig, gnt, pop, wr;
  assign rsp_valid = {cnt_q[1] != '0, cnt_q[0] != '0};
  assign rsp_data0 = rsp_valid[0] ? mem_q[0][rptr_q[0]] : '0;
  assign rsp_data1 = rsp_valid[1] ? mem_q[1][rptr_q[1]] : '0;
  assign dp_valid  = issue_v_q;
  assign dp_op     = op_q;
  assign dp_a      = a_q;
  assign dp_b      = b_q;
  assign busy      = |tag_v_q | issue_v_q | |rsp_valid;
  always_comb begin
    elig       = req_valid & {credit_q[1] != '0, credit_q[0] != '0};
    gnt        = &elig ? (prio_q ? 2'b10 : 2'b01) : elig;
    req_ready  = rstn ? gnt : 2'b00;
    issue_v_d  = |gnt;
    issue_id_d = gnt[1];
    op_d       = |gnt ? (gnt[1] ? req_op[1] : req_op[0]) : op_q;
    a_d        = |gnt ? (gnt[1] ? req_a1 : req_a0) : a_q;
    b_d        = |gnt ? (gnt[1] ? req_b1 : req_b0) : b_q;
    prio_d     = |gnt ? ~gnt[1] : prio_q;
    tag_v_d    = LAT'({tag_v_q, issue_v_q});
    tag_id_d   = LAT'({tag_id_q, issue_id_q});
    wr         = tag_v_q[LAT-1] ? (tag_id_q[LAT-1] ? 2'b10 : 2'b01) : 2'b00;
    pop        = rsp_valid & rsp_ready;
    mem_d      = mem_q;
    for (int i = 0; i < 2; i++) begin
      if (wr[i]) mem_d[i][wptr_q[i]] = dp_result;
      wptr_d[i]   = wr[i] ? inc(wptr_q[i]) : wptr_q[i];
      rptr_d[i]   = pop[i] ? inc(rptr_q[i]) : rptr_q[i];
      cnt_d[i]    = cnt_q[i] + CW'(wr[i]) - CW'(pop[i]);
      credit_d[i] = credit_q[i] + CW'(pop[i]) - CW'(gnt[i]);
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      credit_q   <= '{default: CW'(DEPTH)};
      cnt_q      <= '{default: '0};
      wptr_q     <= '{default: '0};
      rptr_q     <= '{default: '0};
      mem_q      <= '{default: '{default: '0}};
      prio_q     <= 1'b0;
      issue_v_q  <= 1'b0;
      issue_id_q <= 1'b0;
      op_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      tag_v_q    <= '0;
      tag_id_q   <= '0;
    end else begin
      credit_q   <= credit_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      mem_q      <= mem_d;
      prio_q     <= prio_d;
      issue_v_q  <= issue_v_d;
      issue_id_q <= issue_id_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      tag_v_q    <= tag_v_d;
      tag_id_q   <= tag_id_d;
    end
  end
endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: table, directed and random checks of fpu_arbiter against a queue-based reference model
module tb_fpu_arbiter;
  localparam int LAT = 3, DEPTH = 4;
  logic clk = 0, rstn = 1;
  logic [1:0] req_valid, req_ready, req_op, rsp_valid, rsp_ready;
  logic [31:0] req_a0, req_a1, req_b0, req_b1, dp_a, dp_b, dp_result, rsp_data0, rsp_data1;
  logic dp_valid, dp_op, busy;
  always #5 clk = ~clk;
  fpu_arbiter #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1), .req_op(req_op),
    .dp_valid(dp_valid), .dp_op(dp_op), .dp_a(dp_a), .dp_b(dp_b), .dp_result(dp_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
    .busy(busy)
  );
  function automatic real to_r(input logic [31:0] x);
    real r;
    int e;
    r = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return x[31] ? -r : r;
  endfunction
  function automatic logic [31:0] from_r(input real r);
    real a;
    int e;
    logic s;
    if (r == 0.0) return 32'h0;
    s = r < 0.0;
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    return {s, 8'(e + 127), 23'($rtoi((a - 1.0) * 8388608.0))};
  endfunction
  function automatic logic [31:0] dp_fn(input logic [31:0] a, input logic [31:0] b, input logic op);
    return from_r(op ? to_r(a) * to_r(b) : to_r(a) + to_r(b));
  endfunction
  function automatic logic [31:0] rnd_f();
    return {1'($urandom), 8'(120 + $urandom_range(15, 0)), 23'($urandom)};
  endfunction
  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= dp_valid ? dp_fn(dp_a, dp_b, dp_op) : $urandom;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign dp_result = pipe[LAT-1];
  typedef struct { logic [31:0] d; int rdy; } ent_t;
  typedef struct { logic [1:0] rv; logic [1:0] rdy; } vec_t;
  ent_t q0[$], q1[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, prio = 0;
  int acc [2];
  logic pv = 0, po;
  logic [31:0] pa, pb;
  logic [1:0] lastg;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic rand_ops();
    req_a0 = rnd_f(); req_a1 = rnd_f(); req_b0 = rnd_f(); req_b1 = rnd_f();
    req_op = 2'($urandom);
  endtask
  task automatic step();
    logic [1:0] eg, g, vis;
    ent_t e;
    logic id;
    @(negedge clk);
    eg[0] = req_valid[0] && q0.size() < DEPTH;
    eg[1] = req_valid[1] && q1.size() < DEPTH;
    g = (eg == 2'b11) ? (prio == 1 ? 2'b10 : 2'b01) : eg;
    vis[0] = q0.size() > 0 && q0[0].rdy <= cyc;
    vis[1] = q1.size() > 0 && q1[0].rdy <= cyc;
    chk("req_ready", 32'(req_ready), 32'(g));
    chk("dp_valid", 32'(dp_valid), 32'(pv));
    if (pv) begin
      chk("dp_a", dp_a, pa);
      chk("dp_b", dp_b, pb);
      chk("dp_op", 32'(dp_op), 32'(po));
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(vis));
    if (vis[0]) chk("rsp_data0", rsp_data0, q0[0].d);
    if (vis[1]) chk("rsp_data1", rsp_data1, q1[0].d);
    chk("busy", 32'(busy), 32'(q0.size() + q1.size() > 0));
    lastg = req_ready;
    acc[0] += int'(req_ready[0]);
    acc[1] += int'(req_ready[1]);
    if (vis[0] && rsp_ready[0]) void'(q0.pop_front());
    if (vis[1] && rsp_ready[1]) void'(q1.pop_front());
    pv = |g;
    if (pv) begin
      id = g[1];
      pa = id ? req_a1 : req_a0;
      pb = id ? req_b1 : req_b0;
      po = req_op[id];
      e.d = dp_fn(pa, pb, po);
      e.rdy = cyc + LAT + 2;
      if (id) q1.push_back(e); else q0.push_back(e);
      prio = id ? 0 : 1;
    end
    tick();
  endtask
  task automatic do_reset();
    req_valid = 2'b11;
    rstn = 0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_dp_valid", 32'(dp_valid), 0);
    chk("rst_dp_a", dp_a, 0);
    chk("rst_dp_b", dp_b, 0);
    chk("rst_dp_op", 32'(dp_op), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data0", rsp_data0, 0);
    chk("rst_rsp_data1", rsp_data1, 0);
    chk("rst_busy", 32'(busy), 0);
    tick();
    tick();
    rstn = 1;
    req_valid = 2'b00;
    q0.delete();
    q1.delete();
    prio = 0;
    pv = 0;
  endtask
  task automatic drain();
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    for (int n = 0; n < 40 && q0.size() + q1.size() > 0; n++) step();
    step();
    chk("drain_busy", 32'(busy), 0);
  endtask
  initial begin
    vec_t tbl [4];
    int t0, n, d0;
    tbl[0] = '{2'b00, 2'b00};
    tbl[1] = '{2'b01, 2'b01};
    tbl[2] = '{2'b10, 2'b10};
    tbl[3] = '{2'b11, 2'b01};
    req_valid = 0; rsp_ready = 0;
    rand_ops();
    #2;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_valid = tbl[i].rv;
      #1;
      chk("tbl_ready", 32'(req_ready), 32'(tbl[i].rdy));
    end
    req_valid = 2'b00;
    tick();
    rsp_ready = 2'b11;
    for (int k = 0; k < 12; k++) begin
      req_valid = 2'b11;
      rand_ops();
      step();
      chk("alt_grant", 32'(lastg), (k % 2) != 0 ? 32'd2 : 32'd1);
    end
    drain();
    rsp_ready = 2'b00;
    req_valid = 2'b01;
    req_a0 = 32'h3F800000; req_b0 = 32'h40000000; req_op = 2'b00;
    step();
    t0 = cyc - 1;
    req_valid = 2'b00;
    n = 0;
    while (!rsp_valid[0] && n < 12) begin step(); n++; end
    chk("single_lat", 32'(cyc - t0), 32'(LAT + 2));
    chk("single_data", rsp_data0, 32'h40400000);
    drain();
    acc = '{0, 0};
    req_valid = 2'b11;
    rsp_ready = 2'b01;
    for (int k = 0; k < 16; k++) begin
      rand_ops();
      if (k == 8) d0 = acc[0];
      step();
    end
    chk("r1_credit_accepts", 32'(acc[1]), 4);
    chk("r0_not_blocked", 32'(acc[0] > d0), 1);
    rsp_ready = 2'b11;
    step();
    rsp_ready = 2'b01;
    for (int k = 0; k < 8; k++) begin rand_ops(); step(); end
    chk("r1_one_more", 32'(acc[1]), 5);
    req_valid = 2'b10;
    rsp_ready = 2'b10;
    for (int k = 0; k < 12; k++) begin rand_ops(); step(); end
    drain();
    req_valid = 2'b01;
    rsp_ready = 2'b00;
    for (int k = 0; k < 3; k++) begin rand_ops(); step(); end
    do_reset();
    rsp_ready = 2'b11;
    for (int k = 0; k < 12; k++) step();
    acc = '{0, 0};
    req_valid = 2'b10;
    rsp_ready = 2'b00;
    for (int k = 0; k < 8; k++) begin rand_ops(); step(); end
    chk("post_rst_credits", 32'(acc[1]), 4);
    drain();
    for (int k = 0; k < 2000; k++) begin
      req_valid = 2'($urandom);
      rsp_ready = 2'($urandom);
      rand_ops();
      step();
    end
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 Parameter LAT, default 3: fixed latency in cycles from dp_valid to the matching dp_result on the shared FP datapath.
REQ-002 Parameter DEPTH, default 4: result FIFO depth per requester, which also sets the per-requester credit limit.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  2  bit i = requester i presents an operation.
REQ-006 req_ready  output  2  bit i = requester i's operation is accepted this cycle.
REQ-007 req_a0, req_a1  input  32 each  IEEE-754 single-precision operand A per requester.
REQ-008 req_b0, req_b1  input  32 each  IEEE-754 single-precision operand B per requester.
REQ-009 req_op  input  2  bit i = op of requester i (0 add, 1 mul).
REQ-010 dp_valid  output  1  issue strobe to the shared datapath.
REQ-011 dp_op  output  1  issued op (0 add, 1 mul).
REQ-012 dp_a, dp_b  output  32 each  issued operands.
REQ-013 dp_result  input  32  datapath result, valid exactly LAT cycles after the matching dp_valid.
REQ-014 rsp_valid  output  2  bit i = result available for requester i.
REQ-015 rsp_ready  input  2  bit i = requester i consumes its result.
REQ-016 rsp_data0, rsp_data1  output  32 each  head result per requester.
REQ-017 busy  output  1  any operation in flight or any result held.

Function
REQ-018 The block SHALL keep credit[i] (range 0..DEPTH) per requester; requester i is eligible when req_valid[i]=1 and credit[i]>0.
REQ-019 At most one requester SHALL be granted per cycle; req_ready SHALL be combinational, one-hot or zero.
REQ-020 If exactly one requester is eligible, it SHALL be granted.
REQ-021 If both are eligible, the requester not granted most recently SHALL win; after reset requester 0 wins the first tie.
REQ-022 On acceptance at cycle t, the block SHALL register the operands and op, drive dp_valid=1 with dp_a/dp_b/dp_op at cycle t+1, and drive dp_valid=0 in cycles with no acceptance; back-to-back issue every cycle SHALL be supported.
REQ-023 A tag shift register of LAT stages holding {valid, id} SHALL capture dp_result at cycle t+1+LAT into FIFO[id].
REQ-024 Each FIFO SHALL be first-word-fall-through: rsp_valid[i]=FIFO[i] non-empty, rsp_data_i=head, pop on rsp_valid[i]&rsp_ready[i]; per-requester result order SHALL equal acceptance order.
REQ-025 Minimum accept-to-rsp_valid latency SHALL be LAT+2 cycles.
REQ-026 credit[i] SHALL decrement on acceptance for i and increment on pop for i; when both occur in the same cycle credit[i] SHALL be unchanged. Credit SHALL therefore never allow a FIFO write into a full FIFO.
REQ-027 A FIFO write and pop in the same cycle on a full or empty FIFO SHALL both succeed; wrap-around of read/write pointers SHALL be modulo DEPTH.
REQ-028 A requester with credit 0 SHALL see req_ready=0 and SHALL NOT block the other requester.
REQ-029 busy SHALL equal (any tag stage valid) OR (issue register valid) OR (any FIFO non-empty).
REQ-030 dp_result SHALL be ignored in cycles where the final tag stage is invalid.

Reset
REQ-031 While rstn=0: req_ready=0, dp_valid=0, dp_a=dp_b=0, dp_op=0, rsp_valid=0, rsp_data0=rsp_data1=0, busy=0, credits=DEPTH, FIFOs empty, tags invalid, tie pointer selects requester 0.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight and held results; no rsp_valid SHALL assert for them after release.

Verification
REQ-033 Single op: requester 0 add, 0x3F800000+0x40000000, model returns 0x40400000 -> dp_valid at t+1, rsp_valid[0] at t+5 (LAT=3), rsp_data0=0x40400000.
REQ-034 Both valid every cycle, rsp_ready=11 -> grants alternate 0,1,0,1 starting with 0; each requester receives results in its own issue order.
REQ-035 Requester 1 with rsp_ready[1]=0 issues continuously -> exactly 4 accepts, then req_ready[1]=0 while requester 0 continues at full rate; one pop -> exactly one further accept.
REQ-036 FIFO full with pop and arriving write in the same cycle -> both succeed, credit unchanged, no data lost or duplicated.
REQ-037 rstn pulsed low with 3 ops in flight -> all outputs at reset values immediately, credits=4, no stale rsp_valid within 10 cycles after release.
